// File: rtl/mem_arbiter.sv
// mem_arbiter: single-port SRAM arbiter between a CPU and a host port, with a host starvation guard.
// Optional ARB_HALT_EN adds cpu_halt, which locks the CPU out of arbitration while high.
module mem_arbiter #(
    parameter int MEM_LAT    = 1,
    parameter int STARVE_MAX = 4
) (
    input  logic        clkin,
    input  logic        rst_n,
`ifdef ARB_HALT_EN
    input  logic        cpu_halt,
`endif
    input  logic        cpu_en,
    input  logic        cpu_rdwr,
    input  logic [11:0] cpu_addr,
    input  logic [15:0] cpu_wdata,
    output logic [15:0] cpu_rdata,
    output logic        cpu_ack,
    output logic        cpu_stall,
    input  logic        host_req,
    input  logic        host_we,
    input  logic [11:0] host_addr,
    input  logic [15:0] host_wdata,
    output logic [15:0] host_rdata,
    output logic        host_ack,
    output logic        mem_csb,
    output logic        mem_web,
    output logic [11:0] mem_addr,
    output logic [15:0] mem_din,
    input  logic [15:0] mem_dout
);
    typedef enum logic [1:0] {IDLE, CMD, WAIT, DONE} state_t;

    state_t      state_q;
    logic [3:0]  starve_q;
    logic [1:0]  lat_q;
    logic        host_gnt_q;
    logic        mem_csb_q, mem_web_q, cpu_ack_q, host_ack_q;
    logic [11:0] mem_addr_q;
    logic [15:0] mem_din_q, cpu_rdata_q, host_rdata_q;
    logic        halt, cpu_req, host_wins, finish;

`ifdef ARB_HALT_EN
    assign halt = cpu_halt;
`else
    assign halt = 1'b0;
`endif

    assign cpu_req   = cpu_en & ~halt;
    assign host_wins = host_req & (~cpu_req | (starve_q == 4'(STARVE_MAX)));
    // Writes finish straight out of CMD; reads do too when the SRAM answers in one clock.
    assign finish    = (state_q == CMD && (!mem_web_q || MEM_LAT == 1)) ||
                       (state_q == WAIT && lat_q == 2'd0);

    always_ff @(posedge clkin or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            starve_q     <= 4'd0;
            lat_q        <= 2'd0;
            host_gnt_q   <= 1'b0;
            mem_csb_q    <= 1'b1;
            mem_web_q    <= 1'b1;
            mem_addr_q   <= 12'd0;
            mem_din_q    <= 16'd0;
            cpu_rdata_q  <= 16'd0;
            host_rdata_q <= 16'd0;
            cpu_ack_q    <= 1'b0;
            host_ack_q   <= 1'b0;
        end else begin
            cpu_ack_q  <= 1'b0;
            host_ack_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    starve_q <= (host_req & cpu_req & ~host_wins) ? starve_q + 4'd1 : 4'd0;
                    if (cpu_req | host_req) begin
                        state_q    <= CMD;
                        host_gnt_q <= host_wins;
                        mem_csb_q  <= 1'b0;
                        mem_addr_q <= host_wins ? host_addr : cpu_addr;
                        mem_din_q  <= host_wins ? host_wdata : cpu_wdata;
                        mem_web_q  <= host_wins ? ~host_we : ~cpu_rdwr;
                    end
                end
                CMD: begin
                    mem_csb_q <= 1'b1;
                    lat_q     <= 2'(MEM_LAT - 2);
                    state_q   <= WAIT;
                end
                WAIT: lat_q <= lat_q - 2'd1;
                DONE: begin
                    mem_web_q <= 1'b1;
                    state_q   <= IDLE;
                end
            endcase
            if (finish) begin
                state_q    <= DONE;
                cpu_ack_q  <= ~host_gnt_q;
                host_ack_q <= host_gnt_q;
                if (mem_web_q & ~host_gnt_q) cpu_rdata_q <= mem_dout;
                if (mem_web_q & host_gnt_q) host_rdata_q <= mem_dout;
            end
        end
    end

    assign cpu_stall  = halt | (cpu_en & ~cpu_ack_q);
    assign cpu_ack    = cpu_ack_q;
    assign host_ack   = host_ack_q;
    assign cpu_rdata  = cpu_rdata_q;
    assign host_rdata = host_rdata_q;
    assign mem_csb    = mem_csb_q;
    assign mem_web    = mem_web_q;
    assign mem_addr   = mem_addr_q;
    assign mem_din    = mem_din_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed bench for mem_arbiter with an SRAM model and an ack scoreboard.
// Build with ARB_HALT_EN defined to also exercise cpu_halt.
module tb_mem_arbiter;
    localparam int LAT  = 2;
    localparam int SMAX = 4;

    logic        clkin = 1'b0;
    logic        rst_n = 1'b0;
    logic        cpu_en = 1'b0, cpu_rdwr = 1'b0;
    logic [11:0] cpu_addr = 12'd0;
    logic [15:0] cpu_wdata = 16'd0;
    logic [15:0] cpu_rdata;
    logic        cpu_ack, cpu_stall;
    logic        host_req = 1'b0, host_we = 1'b0;
    logic [11:0] host_addr = 12'd0;
    logic [15:0] host_wdata = 16'd0;
    logic [15:0] host_rdata;
    logic        host_ack;
    logic        mem_csb, mem_web;
    logic [11:0] mem_addr;
    logic [15:0] mem_din, mem_dout;
`ifdef ARB_HALT_EN
    logic        cpu_halt = 1'b0;
`endif

    typedef struct {logic host; logic we; logic [15:0] data;} exp_t;
    exp_t        sb[$];
    logic [15:0] ref_mem [4096];
    logic [15:0] sram [4096];
    logic [15:0] exp_cpu_rd = 16'd0, exp_host_rd = 16'd0;
    int          n_chk = 0, n_fail = 0;

    mem_arbiter #(.MEM_LAT(LAT), .STARVE_MAX(SMAX)) dut (
        .clkin(clkin), .rst_n(rst_n),
`ifdef ARB_HALT_EN
        .cpu_halt(cpu_halt),
`endif
        .cpu_en(cpu_en), .cpu_rdwr(cpu_rdwr), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack), .cpu_stall(cpu_stall),
        .host_req(host_req), .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
        .host_rdata(host_rdata), .host_ack(host_ack),
        .mem_csb(mem_csb), .mem_web(mem_web), .mem_addr(mem_addr), .mem_din(mem_din),
        .mem_dout(mem_dout)
    );

    always #5 clkin = ~clkin;

    always @(posedge clkin) if (!mem_csb && !mem_web) sram[mem_addr] <= mem_din;
    assign mem_dout = sram[mem_addr];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    always @(negedge clkin) begin
        if (rst_n && (cpu_ack || host_ack)) begin
            exp_t e;
            check("ack_exclusive", 32'(cpu_ack & host_ack), 32'd0);
            check("ack_expected", 32'(sb.size() != 0), 32'd1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                check("ack_source", 32'(host_ack), 32'(e.host));
                if (!e.we && e.host) exp_host_rd = e.data;
                if (!e.we && !e.host) exp_cpu_rd = e.data;
                check("cpu_rdata", 32'(cpu_rdata), 32'(exp_cpu_rd));
                check("host_rdata", 32'(host_rdata), 32'(exp_host_rd));
            end
        end
    end

    task automatic access(input logic host, input logic we, input logic [11:0] a,
                          input logic [15:0] d, input logic drop);
        int   n;
        logic hit;
        if (host) begin host_req = 1'b1; host_we = we; host_addr = a; host_wdata = d; end
        else begin cpu_en = 1'b1; cpu_rdwr = we; cpu_addr = a; cpu_wdata = d; end
        if (we) ref_mem[a] = d;
        sb.push_back('{host, we, ref_mem[a]});
        #1;
        if (!host) check("cpu_stall_wait", 32'(cpu_stall), 32'd1);
        hit = 1'b0;
        for (int i = 0; i < 20 && !hit; i++) begin
            @(posedge clkin); #1;
            hit = !mem_csb;
        end
        check("grant_seen", 32'(hit), 32'd1);
        check("cmd_addr", 32'(mem_addr), 32'(a));
        check("cmd_web", 32'(mem_web), 32'(!we));
        if (we) check("cmd_din", 32'(mem_din), 32'(d));
        if (drop && host) begin host_req = 1'b0; host_we = ~we; host_addr = ~a; host_wdata = ~d; end
        if (drop && !host) begin cpu_en = 1'b0; cpu_rdwr = ~we; cpu_addr = ~a; cpu_wdata = ~d; end
        hit = 1'b0;
        n = 0;
        for (int i = 0; i < 10 && !hit; i++) begin
            @(posedge clkin); #1;
            n++;
            hit = host ? host_ack : cpu_ack;
        end
        check("ack_latency", 32'(n), we ? 32'd1 : 32'(LAT));
        if (!host && !drop) check("cpu_stall_ack", 32'(cpu_stall), 32'd0);
        if (host) host_req = 1'b0; else cpu_en = 1'b0;
        @(posedge clkin); #1;
    endtask

    initial begin
        logic hit;
        int   acks, g1, g2;
        #12;
        check("rst_csb", 32'(mem_csb), 32'd1);
        check("rst_web", 32'(mem_web), 32'd1);
        check("rst_addr", 32'(mem_addr), 32'd0);
        check("rst_din", 32'(mem_din), 32'd0);
        check("rst_cpu_rdata", 32'(cpu_rdata), 32'd0);
        check("rst_host_rdata", 32'(host_rdata), 32'd0);
        check("rst_acks", 32'({cpu_ack, host_ack}), 32'd0);
        #5 rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clkin); #1;
            check("idle_cs_we", 32'({mem_csb, mem_web}), 32'd3);
        end

        access(1'b0, 1'b1, 12'h123, 16'hBEEF, 1'b0);
        access(1'b0, 1'b0, 12'h123, 16'h0000, 1'b0);
        access(1'b1, 1'b1, 12'hFFF, 16'h0A5A, 1'b0);
        access(1'b1, 1'b0, 12'hFFF, 16'h0000, 1'b0);
        access(1'b0, 1'b1, 12'h0AA, 16'h1234, 1'b1);
        access(1'b0, 1'b0, 12'h0AA, 16'h0000, 1'b1);
        access(1'b1, 1'b0, 12'h123, 16'h0000, 1'b1);

        sb.push_back('{1'b0, 1'b1, 16'h5555});
        sb.push_back('{1'b0, 1'b1, 16'h5555});
        ref_mem[12'h400] = 16'h5555;
        cpu_en = 1'b1; cpu_rdwr = 1'b1; cpu_addr = 12'h400; cpu_wdata = 16'h5555;
        g1 = -1; g2 = -1; acks = 0;
        for (int i = 0; i < 40 && acks < 2; i++) begin
            @(posedge clkin); #1;
            if (!mem_csb && g1 < 0) g1 = i;
            else if (!mem_csb) g2 = i;
            if (cpu_ack) acks++;
        end
        cpu_en = 1'b0;
        check("hold_acks", 32'(acks), 32'd2);
        check("regrant_gap", 32'(g2 - g1), 32'd3);
        @(posedge clkin); #1;

        ref_mem[12'h300] = 16'h1111;
        ref_mem[12'h301] = 16'h2222;
        for (int r = 0; r < 2; r++) begin
            for (int k = 0; k < SMAX; k++) sb.push_back('{1'b0, 1'b1, 16'h1111});
            sb.push_back('{1'b1, 1'b1, 16'h2222});
        end
        cpu_en = 1'b1; cpu_rdwr = 1'b1; cpu_addr = 12'h300; cpu_wdata = 16'h1111;
        host_req = 1'b1; host_we = 1'b1; host_addr = 12'h301; host_wdata = 16'h2222;
        acks = 0;
        for (int i = 0; i < 100 && acks < 2 * (SMAX + 1); i++) begin
            @(posedge clkin); #1;
            if (cpu_ack || host_ack) acks++;
        end
        cpu_en = 1'b0; host_req = 1'b0;
        check("starve_acks", 32'(acks), 32'(2 * (SMAX + 1)));
        @(posedge clkin); #1;
        access(1'b1, 1'b0, 12'h301, 16'h0000, 1'b0);

        cpu_en = 1'b1; cpu_rdwr = 1'b0; cpu_addr = 12'h123;
        hit = 1'b0;
        for (int i = 0; i < 20 && !hit; i++) begin
            @(posedge clkin); #1;
            hit = !mem_csb;
        end
        check("abort_grant", 32'(hit), 32'd1);
        @(posedge clkin); #1;
        check("abort_wait_ack", 32'(cpu_ack), 32'd0);
        rst_n = 1'b0; cpu_en = 1'b0;
        exp_cpu_rd = 16'd0; exp_host_rd = 16'd0;
        #1;
        check("abort_csb", 32'(mem_csb), 32'd1);
        check("abort_web", 32'(mem_web), 32'd1);
        check("abort_addr", 32'(mem_addr), 32'd0);
        check("abort_cpu_rdata", 32'(cpu_rdata), 32'd0);
        check("abort_host_rdata", 32'(host_rdata), 32'd0);
        repeat (2) @(posedge clkin);
        #3 rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(posedge clkin); #1;
            check("abort_no_ack", 32'({cpu_ack, mem_csb}), 32'd1);
        end
        access(1'b0, 1'b0, 12'h123, 16'h0000, 1'b0);

`ifdef ARB_HALT_EN
        for (int i = 0; i < 4; i++) access(1'b1, 1'b1, 12'(i), 16'(16'h1000 + i), 1'b0);
        cpu_halt = 1'b1; cpu_en = 1'b1; cpu_rdwr = 1'b0; cpu_addr = 12'h010;
        for (int i = 0; i < 4; i++) begin
            access(1'b1, 1'b0, 12'(i), 16'h0000, 1'b0);
            check("halt_stall", 32'(cpu_stall), 32'd1);
            check("halt_no_cpu_ack", 32'(cpu_ack), 32'd0);
        end
        cpu_en = 1'b0; cpu_halt = 1'b0;
        @(posedge clkin); #1;
`endif

        check("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1);
    end
endmodule
